key_input_conditioner: RTL and testbench
========================================

KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of push-button inputs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stable-cycle count for press/release acceptance (20 ms at 50 MHz), legal minimum 2.
REQ-003 SHALL have parameter KEYS_ACTIVE_LOW, default 1: 1 inverts raw inputs (DE1-SoC KEY), 0 passes them unchanged.
REQ-004 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port raw_keys  input  NUM_KEYS  asynchronous push-button levels.
REQ-007 SHALL have port key_pulse  output  NUM_KEYS  one-hot, one-cycle strobe per accepted press; feeds the lock FSM key input.
REQ-008 SHALL have port key_held  output  NUM_KEYS  one-hot accepted key while it is held.
REQ-009 SHALL have port multi_key_pulse  output  1  one-cycle strobe on rejected multi-key press.
REQ-010 SHALL have port ready  output  1  high while in IDLE.

Function
REQ-011 SHALL pass each raw_keys bit, after polarity correction, through a two-flop synchronizer; "pattern" below means the second-flop value, 1 = pressed.
REQ-012 SHALL implement states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT with one counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 In IDLE, all-zero pattern SHALL stay in IDLE; exactly one bit set SHALL capture that bit, clear counter, go PRESS_WAIT.
REQ-014 In IDLE or PRESS_WAIT, two or more bits set SHALL assert multi_key_pulse for one cycle, clear key_held, go HELD, never emit key_pulse for that press.
REQ-015 In PRESS_WAIT, pattern equal to captured key SHALL increment counter; at the edge where counter equals DEBOUNCE_CYCLES-1 it SHALL register key_pulse = captured key, key_held = captured key, go HELD.
REQ-016 In PRESS_WAIT, all-zero pattern or a different single key SHALL return to IDLE with counter cleared and no pulse (bounce rejection).
REQ-017 In HELD, all-zero pattern SHALL clear counter and go RELEASE_WAIT; any other pattern SHALL stay HELD.
REQ-018 In RELEASE_WAIT, any nonzero pattern SHALL return to HELD with counter cleared; all-zero increments counter and at DEBOUNCE_CYCLES-1 SHALL clear key_held and go IDLE.
REQ-019 key_pulse and multi_key_pulse SHALL be registered and high for exactly one cycle per event, never simultaneously.
REQ-020 Press latency SHALL be fixed: raw press first sampled at edge 1 -> key_pulse high for the cycle after edge 3+DEBOUNCE_CYCLES.
REQ-021 A key held indefinitely SHALL produce exactly one key_pulse; no auto-repeat.
REQ-022 Counter SHALL never wrap; it saturates by state exit.

Reset
REQ-023 On reset SHALL set synchronizer flops to released, key_pulse=0, key_held=0, multi_key_pulse=0, counter=0, state=RELEASE_WAIT, ready=0.
REQ-024 A key held across reset SHALL generate no key_pulse until released for DEBOUNCE_CYCLES cycles and pressed again.
REQ-025 Reset asserted mid-PRESS_WAIT SHALL suppress a pending key_pulse in that same cycle.

Verification (DEBOUNCE_CYCLES=4, KEYS_ACTIVE_LOW=1)
REQ-026 Reset, keys released 8 cycles, raw_keys=4'b1101 held -> key_pulse=4'b0010 exactly after edge 7 only, key_held=4'b0010 until release debounced.
REQ-027 From IDLE, raw_keys=4'b1110 for 2 cycles, 4'b1111 for 1, 4'b1110 held -> counter restarts; single key_pulse=4'b0001 4+3 edges after final press sampled.
REQ-028 From IDLE, raw_keys=4'b1100 -> multi_key_pulse one cycle, key_pulse stays 0, ready=1 only after 4 released cycles.
REQ-029 raw_keys=4'b0111 held through reset and 20 cycles after -> no key_pulse; release 4 cycles then press -> one key_pulse=4'b1000.
REQ-030 Release bounce: in HELD, 2 released cycles then press glitch then release -> returns HELD, no second pulse, IDLE after 4 clean released cycles.

Source files
------------

// File: rtl/key_input_conditioner.sv
// Push-button front end: polarity correction, two-flop synchronizer, and a
// single-key debounce FSM that emits one press strobe per accepted press.
module key_input_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit KEYS_ACTIVE_LOW = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] raw_keys,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                multi_key_pulse,
    output logic                ready
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

    function automatic logic is_multi(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && !is_one_hot(v);
    endfunction

    logic [NUM_KEYS-1:0] pressed_raw;
    logic [NUM_KEYS-1:0] sync_p0;
    logic [NUM_KEYS-1:0] sync_p1;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    counter;
    logic [CNT_W-1:0]    counter_nxt;
    logic [NUM_KEYS-1:0] captured;
    logic [NUM_KEYS-1:0] captured_nxt;
    logic [NUM_KEYS-1:0] pulse_nxt;
    logic [NUM_KEYS-1:0] held_nxt;
    logic                multi_nxt;

    assign pressed_raw = KEYS_ACTIVE_LOW ? ~raw_keys : raw_keys;

    // Stage p0/p1: metastability filter; reset value is "released".
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pressed_raw;
            sync_p1 <= sync_p0;
        end
    end

    // FSM registers; reset lands in RELEASE_WAIT so a key held through
    // reset has to be seen released before it can be accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= RELEASE_WAIT;
            counter         <= '0;
            key_pulse       <= '0;
            key_held        <= '0;
            multi_key_pulse <= 1'b0;
        end else begin
            state           <= state_nxt;
            counter         <= counter_nxt;
            key_pulse       <= pulse_nxt;
            key_held        <= held_nxt;
            multi_key_pulse <= multi_nxt;
        end
    end

    always_ff @(posedge clock) begin
        captured <= captured_nxt;
    end

    always_comb begin
        state_nxt    = state;
        counter_nxt  = counter;
        captured_nxt = captured;
        pulse_nxt    = '0;
        held_nxt     = key_held;
        multi_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (is_multi(sync_p1)) begin
                    multi_nxt   = 1'b1;
                    held_nxt    = '0;
                    counter_nxt = '0;
                    state_nxt   = HELD;
                end else if (is_one_hot(sync_p1)) begin
                    captured_nxt = sync_p1;
                    counter_nxt  = '0;
                    state_nxt    = PRESS_WAIT;
                end
            end

            PRESS_WAIT: begin
                if (is_multi(sync_p1)) begin
                    multi_nxt   = 1'b1;
                    held_nxt    = '0;
                    counter_nxt = '0;
                    state_nxt   = HELD;
                end else if (sync_p1 == captured) begin
                    if (counter == CNT_LAST) begin
                        pulse_nxt   = captured;
                        held_nxt    = captured;
                        counter_nxt = '0;
                        state_nxt   = HELD;
                    end else begin
                        counter_nxt = counter + CNT_W'(1);
                    end
                end else begin
                    // Released or a different key: treat as bounce.
                    counter_nxt = '0;
                    state_nxt   = IDLE;
                end
            end

            HELD: begin
                if (sync_p1 == '0) begin
                    counter_nxt = '0;
                    state_nxt   = RELEASE_WAIT;
                end
            end

            RELEASE_WAIT: begin
                if (sync_p1 != '0) begin
                    counter_nxt = '0;
                    state_nxt   = HELD;
                end else if (counter == CNT_LAST) begin
                    held_nxt    = '0;
                    counter_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    counter_nxt = counter + CNT_W'(1);
                end
            end

            default: begin
                counter_nxt = '0;
                state_nxt   = RELEASE_WAIT;
            end
        endcase
    end

    assign ready = (state == IDLE);

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with DEBOUNCE_CYCLES=4, active-low keys.
module tb_key_input_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] raw_keys = 4'b1111;
    logic [3:0] key_pulse;
    logic [3:0] key_held;
    logic       multi_key_pulse;
    logic       ready;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    key_input_conditioner #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (4),
        .KEYS_ACTIVE_LOW (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .raw_keys        (raw_keys),
        .key_pulse       (key_pulse),
        .key_held        (key_held),
        .multi_key_pulse (multi_key_pulse),
        .ready           (ready)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_pulse", key_pulse, 4'b0000);
        check("rst_held", key_held, 4'b0000);
        check("rst_multi", {3'b000, multi_key_pulse}, 4'b0000);
        check("rst_ready", {3'b000, ready}, 4'b0000);
        reset = 1'b0;
        tick(3);
        check("boot_ready_e3", {3'b000, ready}, 4'b0000);
        tick(1);
        check("boot_ready_e4", {3'b000, ready}, 4'b0001);
        tick(4);
        check("boot_ready_e8", {3'b000, ready}, 4'b0001);

        // Clean press of key 1: pulse only after edge 7
        raw_keys = 4'b1101;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check($sformatf("k1_pulse_e%0d", i), key_pulse, (i == 7) ? 4'b0010 : 4'b0000);
            check($sformatf("k1_held_e%0d", i), key_held, (i >= 7) ? 4'b0010 : 4'b0000);
            check($sformatf("k1_multi_e%0d", i), {3'b000, multi_key_pulse}, 4'b0000);
        end
        raw_keys = 4'b1111;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check($sformatf("k1_rel_held_e%0d", i), key_held, (i < 7) ? 4'b0010 : 4'b0000);
            check($sformatf("k1_rel_ready_e%0d", i), {3'b000, ready}, (i >= 7) ? 4'b0001 : 4'b0000);
        end

        // Press bounce restarts the debounce count
        raw_keys = 4'b1110;
        tick(2);
        raw_keys = 4'b1111;
        tick(1);
        raw_keys = 4'b1110;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check($sformatf("bounce_pulse_e%0d", i), key_pulse, (i == 7) ? 4'b0001 : 4'b0000);
        end
        check("bounce_held", key_held, 4'b0001);
        raw_keys = 4'b1111;
        tick(8);
        check("bounce_rel_ready", {3'b000, ready}, 4'b0001);
        check("bounce_rel_held", key_held, 4'b0000);

        // Two keys at once: rejected with multi strobe
        raw_keys = 4'b1100;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check($sformatf("multi_strobe_e%0d", i), {3'b000, multi_key_pulse}, (i == 3) ? 4'b0001 : 4'b0000);
            check($sformatf("multi_pulse_e%0d", i), key_pulse, 4'b0000);
            check($sformatf("multi_held_e%0d", i), key_held, 4'b0000);
        end
        check("multi_ready", {3'b000, ready}, 4'b0000);
        raw_keys = 4'b1111;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            check($sformatf("multi_rel_ready_e%0d", i), {3'b000, ready}, (i == 7) ? 4'b0001 : 4'b0000);
        end

        // Key 3 held through reset: no pulse until released and pressed again
        raw_keys = 4'b0111;
        reset = 1'b1;
        tick(2);
        check("hold_rst_pulse", key_pulse, 4'b0000);
        check("hold_rst_ready", {3'b000, ready}, 4'b0000);
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            check($sformatf("hold_pulse_e%0d", i), key_pulse, 4'b0000);
            check($sformatf("hold_ready_e%0d", i), {3'b000, ready}, 4'b0000);
        end
        raw_keys = 4'b1111;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check($sformatf("hold_rel_pulse_e%0d", i), key_pulse, 4'b0000);
        end
        check("hold_rel_ready", {3'b000, ready}, 4'b0001);
        raw_keys = 4'b0111;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check($sformatf("repress_pulse_e%0d", i), key_pulse, (i == 7) ? 4'b1000 : 4'b0000);
        end
        check("repress_held", key_held, 4'b1000);
        raw_keys = 4'b1111;
        tick(8);
        check("repress_rel_ready", {3'b000, ready}, 4'b0001);

        // Release bounce: glitch during release returns to HELD
        raw_keys = 4'b1110;
        tick(8);
        check("relb_held_start", key_held, 4'b0001);
        raw_keys = 4'b1111;
        tick(2);
        raw_keys = 4'b1110;
        tick(1);
        raw_keys = 4'b1111;
        check("relb_held_e3", key_held, 4'b0001);
        for (int i = 4; i <= 12; i++) begin
            tick(1);
            check($sformatf("relb_pulse_e%0d", i), key_pulse, 4'b0000);
            check($sformatf("relb_held_e%0d", i), key_held, (i < 10) ? 4'b0001 : 4'b0000);
            check($sformatf("relb_ready_e%0d", i), {3'b000, ready}, (i >= 10) ? 4'b0001 : 4'b0000);
        end

        // Reset on the edge that would emit the pulse suppresses it
        raw_keys = 4'b1011;
        tick(6);
        check("rstpw_pulse_e6", key_pulse, 4'b0000);
        check("rstpw_ready_e6", {3'b000, ready}, 4'b0000);
        reset = 1'b1;
        tick(1);
        check("rstpw_pulse_e7", key_pulse, 4'b0000);
        check("rstpw_held_e7", key_held, 4'b0000);
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check($sformatf("rstpw_after_pulse_e%0d", i), key_pulse, 4'b0000);
        end
        raw_keys = 4'b1111;
        tick(10);
        check("rstpw_final_ready", {3'b000, ready}, 4'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
